// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared types and helpers for the gate1 IJTAG test data register.
// Operation decode gives capture > shift > update priority, all gated by segment select.
package firebird7_in_gate1_tdr_pkg;

   localparam int unsigned TDR_WIDTH = 3;
   localparam int unsigned TDR_LEN   = TDR_WIDTH + 1;
   localparam int unsigned SEL_BIT   = TDR_WIDTH;

   typedef struct packed {
      logic                 sel;
      logic [TDR_WIDTH-1:0] data;
   } tdr_word_t;

   typedef enum logic [1:0] {
      OP_HOLD    = 2'd0,
      OP_CAPTURE = 2'd1,
      OP_SHIFT   = 2'd2,
      OP_UPDATE  = 2'd3
   } tdr_op_e;

   // Only the highest-priority enable acts; a deselected segment always holds.
   function automatic tdr_op_e decode_op(input logic sel,
                                         input logic ce,
                                         input logic se,
                                         input logic ue);
      tdr_op_e op;
      op = OP_HOLD;
      if (sel) begin
         if (ce)      op = OP_CAPTURE;
         else if (se) op = OP_SHIFT;
         else if (ue) op = OP_UPDATE;
      end
      return op;
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_16_if.sv
// IJTAG segment bundle between the scan network (master) and the TDR (slave).
// Also carries the mux-facing functional/select/data signals.
interface firebird7_in_gate1_tessent_tdr_w3_16_if #(
   parameter int unsigned WIDTH = 3
);

   logic             ijtag_sel;
   logic             ijtag_ce;
   logic             ijtag_se;
   logic             ijtag_ue;
   logic             ijtag_si;
   logic             ijtag_so;
   logic [WIDTH-1:0] functional_data_in;
   logic [WIDTH-1:0] ijtag_data_out;
   logic             ijtag_select_out;

   modport master (
      output ijtag_sel,
      output ijtag_ce,
      output ijtag_se,
      output ijtag_ue,
      output ijtag_si,
      output functional_data_in,
      input  ijtag_so,
      input  ijtag_data_out,
      input  ijtag_select_out
   );

   modport slave (
      input  ijtag_sel,
      input  ijtag_ce,
      input  ijtag_se,
      input  ijtag_ue,
      input  ijtag_si,
      input  functional_data_in,
      output ijtag_so,
      output ijtag_data_out,
      output ijtag_select_out
   );

endinterface

// File: rtl/firebird7_in_gate1_tdr_cell.sv
// One capture/shift/update bit of the TDR: shift flop plus shadow update flop.
// Synchronous active-high reset clears the shift flop and loads UPD_RESET into the update flop.
module firebird7_in_gate1_tdr_cell
   import firebird7_in_gate1_tdr_pkg::*;
#(
   parameter logic UPD_RESET = 1'b0
) (
   input  logic    clk,
   input  logic    rst,
   input  tdr_op_e op,
   input  logic    cap_d,
   input  logic    si,
   output logic    so,
   output logic    upd_q
);

   logic shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= 1'b0;
         upd_q   <= UPD_RESET;
      end else begin
         unique case (op)
            OP_CAPTURE: shift_q <= cap_d;
            OP_SHIFT:   shift_q <= si;
            OP_UPDATE:  upd_q   <= shift_q;
            default:    ;
         endcase
      end
   end

   assign so = shift_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_16.sv
// Gate1 IJTAG TDR driving the data mux select/data from a WIDTH+1 bit scan segment.
// Define TDR_CAPTURE_FUNCTIONAL_EN to capture {select, functional_data_in} instead of readback.
module firebird7_in_gate1_tessent_tdr_w3_16
   import firebird7_in_gate1_tdr_pkg::*;
#(
   parameter int unsigned      WIDTH        = TDR_WIDTH,
   parameter logic [WIDTH-1:0] DATA_RESET   = '0,
   parameter logic             SELECT_RESET = 1'b0
) (
   input logic                                    ijtag_tck,
   input logic                                    ijtag_reset,
   firebird7_in_gate1_tessent_tdr_w3_16_if.slave  tdr_if
);

   localparam logic [WIDTH:0] UPD_RESET = {SELECT_RESET, DATA_RESET};

   tdr_op_e        op;
   logic [WIDTH:0] shift_q;
   logic [WIDTH:0] upd_q;
   logic [WIDTH:0] cap_d;
   logic [WIDTH:0] chain_in;

   always_comb begin
      op = decode_op(tdr_if.ijtag_sel, tdr_if.ijtag_ce, tdr_if.ijtag_se, tdr_if.ijtag_ue);
   end

`ifdef TDR_CAPTURE_FUNCTIONAL_EN
   // Observe live functional data alongside the currently applied select.
   assign cap_d = {upd_q[WIDTH], tdr_if.functional_data_in};
`else
   logic unused_functional;
   assign unused_functional = ^tdr_if.functional_data_in;
   assign cap_d             = upd_q;
`endif

   // Serial path runs MSB to LSB: si enters the select bit, so leaves from bit 0.
   assign chain_in = {tdr_if.ijtag_si, shift_q[WIDTH:1]};

   for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
      firebird7_in_gate1_tdr_cell #(
         .UPD_RESET (UPD_RESET[i])
      ) u_cell (
         .clk   (ijtag_tck),
         .rst   (ijtag_reset),
         .op    (op),
         .cap_d (cap_d[i]),
         .si    (chain_in[i]),
         .so    (shift_q[i]),
         .upd_q (upd_q[i])
      );
   end

   assign tdr_if.ijtag_so         = shift_q[0];
   assign tdr_if.ijtag_data_out   = upd_q[WIDTH-1:0];
   assign tdr_if.ijtag_select_out = upd_q[WIDTH];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_16.sv
// Directed self-checking bench for the gate1 IJTAG TDR (WIDTH=3), both capture configurations.
module tb_firebird7_in_gate1_tessent_tdr_w3_16;

   logic ijtag_tck;
   logic ijtag_reset;
   int   n_checks;
   int   n_pass;
   logic [3:0] exp_seq;

   firebird7_in_gate1_tessent_tdr_w3_16_if #(.WIDTH(3)) tdr_if ();

   firebird7_in_gate1_tessent_tdr_w3_16 #(
      .WIDTH        (3),
      .DATA_RESET   (3'b000),
      .SELECT_RESET (1'b0)
   ) dut (
      .ijtag_tck   (ijtag_tck),
      .ijtag_reset (ijtag_reset),
      .tdr_if      (tdr_if)
   );

   initial ijtag_tck = 1'b0;
   always #5 ijtag_tck = ~ijtag_tck;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge ijtag_tck);
      #1;
   endtask

   task automatic idle();
      tdr_if.ijtag_sel = 1'b0;
      tdr_if.ijtag_ce  = 1'b0;
      tdr_if.ijtag_se  = 1'b0;
      tdr_if.ijtag_ue  = 1'b0;
      tdr_if.ijtag_si  = 1'b0;
   endtask

   task automatic shift1(input logic b);
      tdr_if.ijtag_sel = 1'b1;
      tdr_if.ijtag_se  = 1'b1;
      tdr_if.ijtag_si  = b;
      tick();
      idle();
   endtask

   task automatic update1();
      tdr_if.ijtag_sel = 1'b1;
      tdr_if.ijtag_ue  = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      idle();
      tdr_if.functional_data_in = 3'b000;
      ijtag_reset = 1'b1;

      // 1: reset
      tick();
      tick();
      ijtag_reset = 1'b0;
      check("rst_data", 32'(tdr_if.ijtag_data_out), 32'h0);
      check("rst_sel",  32'(tdr_if.ijtag_select_out), 32'h0);
      check("rst_so",   32'(tdr_if.ijtag_so), 32'h0);

      // 2: shift 1,0,1,1 then update -> shift_reg 4'b1101
      shift1(1'b1); shift1(1'b0); shift1(1'b1); shift1(1'b1);
      check("shift_so",        32'(tdr_if.ijtag_so), 32'h1);
      check("pre_upd_data",    32'(tdr_if.ijtag_data_out), 32'h0);
      update1();
      check("upd_data",        32'(tdr_if.ijtag_data_out), 32'h5);
      check("upd_sel",         32'(tdr_if.ijtag_select_out), 32'h1);

      // 3: capture then shift out
      tdr_if.functional_data_in = 3'b010;
      tdr_if.ijtag_sel = 1'b1;
      tdr_if.ijtag_ce  = 1'b1;
      tick();
      idle();
`ifdef TDR_CAPTURE_FUNCTIONAL_EN
      exp_seq = 4'b1010;
`else
      exp_seq = 4'b1101;
`endif
      for (int k = 0; k < 4; k++) begin
         check($sformatf("cap_so%0d", k), 32'(tdr_if.ijtag_so), 32'(exp_seq[k]));
         check($sformatf("cap_data%0d", k), 32'(tdr_if.ijtag_data_out), 32'h5);
         shift1(1'b0);
      end

      // 4: deselected segment ignores se/ue
      tdr_if.ijtag_sel = 1'b0;
      tdr_if.ijtag_se  = 1'b1;
      tdr_if.ijtag_ue  = 1'b1;
      tdr_if.ijtag_si  = 1'b1;
      tick();
      tick();
      idle();
      check("nosel_data", 32'(tdr_if.ijtag_data_out), 32'h5);
      check("nosel_sel",  32'(tdr_if.ijtag_select_out), 32'h1);
      check("nosel_so",   32'(tdr_if.ijtag_so), 32'h0);
      update1();
      check("nosel_upd_data", 32'(tdr_if.ijtag_data_out), 32'h0);
      check("nosel_upd_sel",  32'(tdr_if.ijtag_select_out), 32'h0);

      // 5: ce+se+ue together -> capture only
      shift1(1'b1); shift1(1'b1); shift1(1'b1); shift1(1'b0);
      update1();
      check("pri_setup_data", 32'(tdr_if.ijtag_data_out), 32'h7);
      check("pri_setup_sel",  32'(tdr_if.ijtag_select_out), 32'h0);
      shift1(1'b0); shift1(1'b0); shift1(1'b0); shift1(1'b0);
      check("pri_clear_so", 32'(tdr_if.ijtag_so), 32'h0);
      tdr_if.functional_data_in = 3'b001;
      tdr_if.ijtag_sel = 1'b1;
      tdr_if.ijtag_ce  = 1'b1;
      tdr_if.ijtag_se  = 1'b1;
      tdr_if.ijtag_ue  = 1'b1;
      tdr_if.ijtag_si  = 1'b1;
      tick();
      idle();
      check("pri_data", 32'(tdr_if.ijtag_data_out), 32'h7);
      check("pri_sel",  32'(tdr_if.ijtag_select_out), 32'h0);
      check("pri_so0",  32'(tdr_if.ijtag_so), 32'h1);
      shift1(1'b0);
`ifdef TDR_CAPTURE_FUNCTIONAL_EN
      check("pri_so1", 32'(tdr_if.ijtag_so), 32'h0);
`else
      check("pri_so1", 32'(tdr_if.ijtag_so), 32'h1);
`endif

      // 6: reset mid-shift wins over enables and discards partial data
      shift1(1'b1);
      shift1(1'b1);
      ijtag_reset = 1'b1;
      tdr_if.ijtag_sel = 1'b1;
      tdr_if.ijtag_se  = 1'b1;
      tdr_if.ijtag_ue  = 1'b1;
      tdr_if.ijtag_si  = 1'b1;
      tick();
      ijtag_reset = 1'b0;
      idle();
      check("midrst_so",   32'(tdr_if.ijtag_so), 32'h0);
      check("midrst_data", 32'(tdr_if.ijtag_data_out), 32'h0);
      check("midrst_sel",  32'(tdr_if.ijtag_select_out), 32'h0);
      update1();
      check("midrst_upd_data", 32'(tdr_if.ijtag_data_out), 32'h0);
      check("midrst_upd_sel",  32'(tdr_if.ijtag_select_out), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
